// File: rtl/writeback_unit_if.sv
// Execution-result and register-file write channels of the write-back stage.
// The slave modport is the write-back unit's view; master is the surrounding pipeline.
interface writeback_unit_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  exe_valid;
   logic [DATA_WIDTH-1:0] exe_result;
   logic [4:0]            exe_rd;
   logic [ADDR_WIDTH-1:0] exe_pc;
   logic                  rf_wr_ready;
   logic                  rf_wr_en;
   logic [4:0]            rf_wr_addr;
   logic [DATA_WIDTH-1:0] rf_wr_data;
   logic [ADDR_WIDTH-1:0] retire_pc;

   modport slave (
      input  exe_valid, exe_result, exe_rd, exe_pc, rf_wr_ready,
      output rf_wr_en, rf_wr_addr, rf_wr_data, retire_pc
   );

   modport master (
      output exe_valid, exe_result, exe_rd, exe_pc, rf_wr_ready,
      input  rf_wr_en, rf_wr_addr, rf_wr_data, retire_pc
   );
endinterface

// File: rtl/writeback_unit.sv
// In-order retire queue draining execution results to the register file,
// with youngest-match bypass, retire counter and overflow-avoiding stall request.
module writeback_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   writeback_unit_if.slave       wb,
   input  logic [4:0]            byp_rs1,
   input  logic [4:0]            byp_rs2,
   output logic                  byp_hit1,
   output logic                  byp_hit2,
   output logic [DATA_WIDTH-1:0] byp_data1,
   output logic [DATA_WIDTH-1:0] byp_data2,
   output logic                  wb_stall_req,
   output logic                  overflow_err,
   output logic [63:0]           instret
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [4:0]            rd_q  [DEPTH];
   logic [DATA_WIDTH-1:0] res_q [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_q  [DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          not_empty, full, head_is_x0, push, pop;

   assign not_empty  = (count != '0);
   assign full       = (count == CW'(DEPTH));
   assign head_is_x0 = (rd_q[rd_ptr] == 5'd0);
   assign pop        = not_empty && (head_is_x0 || wb.rf_wr_ready);
   assign push       = wb.exe_valid && (!full || pop);

   // Head fields are gated so that stale storage never reaches the outputs.
   assign wb.rf_wr_en   = not_empty && !head_is_x0;
   assign wb.rf_wr_addr = not_empty ? rd_q[rd_ptr]  : '0;
   assign wb.rf_wr_data = not_empty ? res_q[rd_ptr] : '0;
   assign wb.retire_pc  = not_empty ? pc_q[rd_ptr]  : '0;

   assign wb_stall_req = (count >= CW'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wr_ptr]  <= wb.exe_rd;
         res_q[wr_ptr] <= wb.exe_result;
         pc_q[wr_ptr]  <= wb.exe_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
         instret      <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + PW'(1);
            instret <= instret + 64'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (wb.exe_valid && full && !pop)
            overflow_err <= 1'b1;
      end
   end

   // Walk from oldest to youngest so the last match (youngest) wins.
   always_comb begin
      logic [PW-1:0] idx;
      byp_hit1  = 1'b0;
      byp_hit2  = 1'b0;
      byp_data1 = '0;
      byp_data2 = '0;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (CW'(i) < count) begin
            if (byp_rs1 != 5'd0 && rd_q[idx] == byp_rs1) begin
               byp_hit1  = 1'b1;
               byp_data1 = res_q[idx];
            end
            if (byp_rs2 != 5'd0 && rd_q[idx] == byp_rs2) begin
               byp_hit2  = 1'b1;
               byp_data2 = res_q[idx];
            end
         end
      end
   end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (DEPTH=4).
module tb_writeback_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  byp_rs1, byp_rs2;
   logic        byp_hit1, byp_hit2;
   logic [31:0] byp_data1, byp_data2;
   logic        wb_stall_req, overflow_err;
   logic [63:0] instret;
   int          n_checks = 0;
   int          n_fail   = 0;

   writeback_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   writeback_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb           (bus),
      .byp_rs1      (byp_rs1),
      .byp_rs2      (byp_rs2),
      .byp_hit1     (byp_hit1),
      .byp_hit2     (byp_hit2),
      .byp_data1    (byp_data1),
      .byp_data2    (byp_data2),
      .wb_stall_req (wb_stall_req),
      .overflow_err (overflow_err),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
      bus.exe_valid  = v;
      bus.exe_rd     = rd;
      bus.exe_result = d;
      bus.exe_pc     = pc;
   endtask

   initial begin
      reset = 1'b1;
      bus.rf_wr_ready = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 32'h0);
      byp_rs1 = 5'd0;
      byp_rs2 = 5'd0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_wr_en", bus.rf_wr_en, 0);
      chk("rst_addr", bus.rf_wr_addr, 0);
      chk("rst_instret", instret, 0);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_stall", wb_stall_req, 0);
      chk("rst_count", dut.count, 0);

      // single result, latency 1
      bus.rf_wr_ready = 1'b1;
      drive(1'b1, 5'd5, 32'hDEADBEEF, 32'h100);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0);
      byp_rs1 = 5'd5;
      #1;
      chk("single_wr_en", bus.rf_wr_en, 1);
      chk("single_addr", bus.rf_wr_addr, 5);
      chk("single_data", bus.rf_wr_data, 32'hDEADBEEF);
      chk("single_pc", bus.retire_pc, 32'h100);
      chk("single_byp_hit", byp_hit1, 1);
      chk("single_byp_data", byp_data1, 32'hDEADBEEF);
      chk("single_instret0", instret, 0);
      tick();
      chk("single_instret1", instret, 1);
      chk("single_empty", dut.count, 0);
      chk("single_wr_en_off", bus.rf_wr_en, 0);
      chk("single_byp_gone", byp_hit1, 0);

      // x0 result pops without a write even with rf_wr_ready low
      bus.rf_wr_ready = 1'b0;
      drive(1'b1, 5'd0, 32'h1234, 32'h200);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("x0_wr_en", bus.rf_wr_en, 0);
      chk("x0_count", dut.count, 1);
      tick();
      chk("x0_popped", dut.count, 0);
      chk("x0_instret", instret, 2);

      // back-pressure fill and overflow
      drive(1'b1, 5'd1, 32'h11, 32'h300);
      tick();
      drive(1'b1, 5'd2, 32'h22, 32'h304);
      tick();
      chk("fill_stall_c2", wb_stall_req, 0);
      drive(1'b1, 5'd3, 32'h33, 32'h308);
      tick();
      chk("fill_count3", dut.count, 3);
      chk("fill_stall_c3", wb_stall_req, 1);
      drive(1'b1, 5'd4, 32'h44, 32'h30C);
      tick();
      chk("fill_count4", dut.count, 4);
      chk("fill_ovf_pre", overflow_err, 0);
      drive(1'b1, 5'd9, 32'h99, 32'h310);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0);
      byp_rs1 = 5'd9;
      byp_rs2 = 5'd3;
      #1;
      chk("ovf_set", overflow_err, 1);
      chk("ovf_count", dut.count, 4);
      chk("ovf_byp_absent", byp_hit1, 0);
      chk("ovf_byp_rd3", byp_data2, 32'h33);
      bus.rf_wr_ready = 1'b1;
      #1;
      chk("drain_addr1", bus.rf_wr_addr, 1);
      chk("drain_pc1", bus.retire_pc, 32'h300);
      tick();
      chk("drain_addr2", bus.rf_wr_addr, 2);
      tick();
      chk("drain_addr3", bus.rf_wr_addr, 3);
      tick();
      chk("drain_addr4", bus.rf_wr_addr, 4);
      chk("drain_data4", bus.rf_wr_data, 32'h44);
      tick();
      chk("drain_empty", dut.count, 0);
      chk("drain_wr_en", bus.rf_wr_en, 0);
      chk("drain_instret", instret, 6);
      chk("ovf_sticky", overflow_err, 1);

      // reset while writes are pending
      bus.rf_wr_ready = 1'b0;
      drive(1'b1, 5'd10, 32'hA0, 32'h400);
      tick();
      drive(1'b1, 5'd11, 32'hA1, 32'h404);
      tick();
      drive(1'b1, 5'd12, 32'hA2, 32'h408);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0);
      bus.rf_wr_ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstmid_wr_en", bus.rf_wr_en, 0);
      chk("rstmid_count", dut.count, 0);
      chk("rstmid_instret", instret, 0);
      chk("rstmid_ovf", overflow_err, 0);
      drive(1'b1, 5'd6, 32'h66, 32'h500);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("post_rst_wr_en", bus.rf_wr_en, 1);
      chk("post_rst_addr", bus.rf_wr_addr, 6);
      tick();
      chk("post_rst_instret", instret, 1);

      // full queue with simultaneous push and pop
      bus.rf_wr_ready = 1'b0;
      drive(1'b1, 5'd1, 32'h51, 32'h600);
      tick();
      drive(1'b1, 5'd2, 32'h52, 32'h604);
      tick();
      drive(1'b1, 5'd3, 32'h53, 32'h608);
      tick();
      drive(1'b1, 5'd4, 32'h54, 32'h60C);
      tick();
      chk("full_count", dut.count, 4);
      bus.rf_wr_ready = 1'b1;
      drive(1'b1, 5'd7, 32'h77, 32'h610);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("pp_count", dut.count, 4);
      chk("pp_no_ovf", overflow_err, 0);
      chk("pp_head", bus.rf_wr_addr, 2);
      chk("pp_instret", instret, 2);
      tick();
      tick();
      tick();
      chk("pp_last_addr", bus.rf_wr_addr, 7);
      chk("pp_last_data", bus.rf_wr_data, 32'h77);
      tick();
      chk("pp_empty", dut.count, 0);
      chk("pp_instret_end", instret, 6);

      // bypass priority and in-flight invisibility
      bus.rf_wr_ready = 1'b0;
      drive(1'b1, 5'd2, 32'hA, 32'h700);
      tick();
      drive(1'b1, 5'd2, 32'hB, 32'h704);
      tick();
      drive(1'b1, 5'd3, 32'hC, 32'h708);
      byp_rs1 = 5'd2;
      byp_rs2 = 5'd0;
      #1;
      chk("byp_hit1", byp_hit1, 1);
      chk("byp_data1", byp_data1, 32'hB);
      chk("byp_hit2_x0", byp_hit2, 0);
      chk("byp_data2_x0", byp_data2, 0);
      byp_rs2 = 5'd3;
      #1;
      chk("byp_inflight", byp_hit2, 0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("byp_visible", byp_hit2, 1);
      chk("byp_visible_data", byp_data2, 32'hC);
      chk("byp_still_young", byp_data1, 32'hB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
